// File: rtl/wmst_out_fm_burst.sv
// wmst_out_fm_burst: packs 32-bit store-FIFO words into byte-enabled single-beat Avalon-MM writes
// and pulses store_trans_done once per row transfer.
module wmst_out_fm_burst #(
    parameter int CW  = 16,
    parameter int DW  = 32,
    parameter int XAW = 32,
    parameter int XDW = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             store_trans_start,
    input  logic [XAW-1:0]   param_waddr,
    input  logic [CW-1:0]    param_iolen,
    output logic             store_trans_done,
    input  logic             store_fifo_empty,
    input  logic [DW-1:0]    store_fifo_rdata,
    output logic             store_fifo_rd,
    output logic [XAW-1:0]   avm_address,
    output logic             avm_write,
    output logic [XDW-1:0]   avm_writedata,
    output logic [XDW/8-1:0] avm_byteenable,
    input  logic             avm_waitrequest
);
    localparam int LANES = XDW / DW;
    localparam int LW    = $clog2(LANES);
    localparam int WB    = $clog2(DW / 8);
    localparam int BEAT  = XDW / 8;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t        state, state_nx;
    logic [LW-1:0] lane;
    logic [CW-1:0] remaining;

    // A beat closes when the top lane is filled or the last word of the row is popped.
    always_comb begin
        state_nx         = state;
        store_fifo_rd    = 1'b0;
        avm_write        = 1'b0;
        store_trans_done = 1'b0;
        case (state)
            IDLE: if (store_trans_start) state_nx = (param_iolen == '0) ? DONE : FILL;
            FILL: begin
                store_fifo_rd = !store_fifo_empty;
                if (!store_fifo_empty && (lane == LW'(LANES - 1) || remaining == CW'(1)))
                    state_nx = WRITE;
            end
            WRITE: begin
                avm_write = 1'b1;
                if (!avm_waitrequest) state_nx = (remaining != '0) ? FILL : DONE;
            end
            DONE: begin
                store_trans_done = 1'b1;
                state_nx         = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            lane           <= '0;
            remaining      <= '0;
            avm_address    <= '0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && store_trans_start) begin
                avm_address    <= param_waddr & ~XAW'(BEAT - 1);
                lane           <= param_waddr[WB +: LW];
                remaining      <= param_iolen;
                avm_byteenable <= '0;
            end
            if (store_fifo_rd) begin
                avm_writedata[DW*lane +: DW]          <= store_fifo_rdata;
                avm_byteenable[(DW/8)*lane +: DW/8]   <= '1;
                lane                                  <= lane + 1'b1;
                remaining                             <= remaining - 1'b1;
            end
            if (avm_write && !avm_waitrequest) begin
                avm_address    <= avm_address + XAW'(BEAT);
                lane           <= '0;
                avm_byteenable <= '0;
            end
        end
    end
endmodule
